// File: rtl/test_scoreboard.sv
// test_scoreboard: gathers completion/failure reports from the test modules
// of the main testbench and turns them into a single verdict
// (PASS / FAIL / TIMEOUT). It also keeps sticky done/fail masks, the index of
// the first failing test and a saturating count of cycles spent running.
//
// Reporting interface (one rule for every reporter bit):
//   test_done[i] is sampled on every rising edge while RUN is active; a high
//   sample is a completion report. test_fail[i] is only meaningful on an edge
//   where test_done[i] is also high. The first completion report of test i is
//   the only one that counts; later reports of the same test are ignored.
//   There is no back-pressure: the scoreboard always accepts reports in RUN.
module test_scoreboard #(
   parameter int N_TESTS        = 8,
   parameter int IDX_W          = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int CNT_W          = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [N_TESTS-1:0] test_done,
   input  logic [N_TESTS-1:0] test_fail,
   output logic               running,
   output logic               all_done,
   output logic               pass,
   output logic               fail,
   output logic               timed_out,
   output logic [N_TESTS-1:0] done_mask,
   output logic [N_TESTS-1:0] fail_mask,
   output logic [IDX_W-1:0]   first_fail_idx,
   output logic               first_fail_valid,
   output logic [CNT_W-1:0]   cycle_count,
   output logic [2:0]         dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_RUN     = 3'd1,
      S_PASS    = 3'd2,
      S_FAIL    = 3'd3,
      S_TIMEOUT = 3'd4
   } state_t;

   // Value of the cycle counter on the last edge allowed before timing out.
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX      = '1;

   state_t               state_q, state_d;
   logic [N_TESTS-1:0]   done_mask_q, done_mask_d;
   logic [N_TESTS-1:0]   fail_mask_q, fail_mask_d;
   logic [IDX_W-1:0]     ff_idx_q, ff_idx_d;
   logic                 ff_valid_q, ff_valid_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   // Failures from tests reporting for the first time on this edge.
   logic [N_TESTS-1:0]   new_fail;
   logic [IDX_W-1:0]     low_fail_idx;
   logic                 low_fail_found;

   assign new_fail = test_done & test_fail & ~done_mask_q;

   // Priority pick of the lowest-numbered new failure.
   always_comb begin
      low_fail_idx   = '0;
      low_fail_found = 1'b0;
      for (int i = 0; i < N_TESTS; i++) begin
         if (new_fail[i] && !low_fail_found) begin
            low_fail_idx   = IDX_W'(i);
            low_fail_found = 1'b1;
         end
      end
   end

   // State register and run records; reset aborts any run without a verdict.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         done_mask_q <= '0;
         fail_mask_q <= '0;
         ff_idx_q    <= '0;
         ff_valid_q  <= 1'b0;
         cnt_q       <= '0;
      end else begin
         state_q     <= state_d;
         done_mask_q <= done_mask_d;
         fail_mask_q <= fail_mask_d;
         ff_idx_q    <= ff_idx_d;
         ff_valid_q  <= ff_valid_d;
         cnt_q       <= cnt_d;
      end
   end

   // Next-state logic: record reports in RUN, decide verdict or timeout.
   always_comb begin
      state_d     = state_q;
      done_mask_d = done_mask_q;
      fail_mask_d = fail_mask_q;
      ff_idx_d    = ff_idx_q;
      ff_valid_d  = ff_valid_q;
      cnt_d       = cnt_q;

      case (state_q)
         // Idle and the terminal states hold their records until a new start.
         S_IDLE, S_PASS, S_FAIL, S_TIMEOUT: begin
            if (start) begin
               state_d     = S_RUN;
               done_mask_d = '0;
               fail_mask_d = '0;
               ff_idx_d    = '0;
               ff_valid_d  = 1'b0;
               cnt_d       = '0;
            end
         end

         S_RUN: begin
            done_mask_d = done_mask_q | test_done;
            fail_mask_d = fail_mask_q | new_fail;
            if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + 1'b1;
            end
            if (!ff_valid_q && low_fail_found) begin
               ff_valid_d = 1'b1;
               ff_idx_d   = low_fail_idx;
            end
            // Completion is judged on the updated masks, so a final report
            // on the timeout edge still yields a verdict.
            if (&done_mask_d) begin
               state_d = (|fail_mask_d) ? S_FAIL : S_PASS;
            end else if (cnt_q == TIMEOUT_LAST) begin
               state_d = S_TIMEOUT;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Outputs are decoded straight from registered state and records.
   assign running          = (state_q == S_RUN);
   assign pass             = (state_q == S_PASS);
   assign fail             = (state_q == S_FAIL);
   assign all_done         = pass | fail;
   assign timed_out        = (state_q == S_TIMEOUT);
   assign done_mask        = done_mask_q;
   assign fail_mask        = fail_mask_q;
   assign first_fail_idx   = ff_idx_q;
   assign first_fail_valid = ff_valid_q;
   assign cycle_count      = cnt_q;
   assign dbg_state        = state_q;

endmodule

// File: tb/tb_test_scoreboard.sv
// Directed bench for test_scoreboard: expected verdict records are queued as
// each run is launched and popped when the run produces its verdict.
module tb_test_scoreboard;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int TO = 20;
  localparam int CW = 16;
  // {pass, fail, timed_out, done_mask, fail_mask, ff_valid, ff_idx, count}
  localparam int W  = 3 + N + N + 1 + IW + CW;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [N-1:0]  test_done = '0;
  logic [N-1:0]  test_fail = '0;
  logic          running, all_done, pass, fail, timed_out, first_fail_valid;
  logic [N-1:0]  done_mask, fail_mask;
  logic [IW-1:0] first_fail_idx;
  logic [CW-1:0] cycle_count;
  logic [2:0]    dbg_state;

  test_scoreboard #(
    .N_TESTS(N), .IDX_W(IW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .test_done(test_done), .test_fail(test_fail),
    .running(running), .all_done(all_done), .pass(pass), .fail(fail),
    .timed_out(timed_out), .done_mask(done_mask), .fail_mask(fail_mask),
    .first_fail_idx(first_fail_idx), .first_fail_valid(first_fail_valid),
    .cycle_count(cycle_count), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] mk_exp(input logic p, input logic f, input logic t,
                                          input logic [N-1:0] dm, input logic [N-1:0] fm,
                                          input logic fv, input logic [IW-1:0] fi,
                                          input logic [CW-1:0] cnt);
    return {p, f, t, dm, fm, fv, fi, cnt};
  endfunction

  task automatic check_verdict(input string tag);
    logic [W-1:0] e;
    checks++;
    assert (exp_q.size() > 0) else begin
      errors++;
      $error("FAIL %s observed=empty_queue expected=record", tag);
    end
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_pass"},  32'(pass),             32'(e[W-1]));
      chk({tag, "_fail"},  32'(fail),             32'(e[W-2]));
      chk({tag, "_tmo"},   32'(timed_out),        32'(e[W-3]));
      chk({tag, "_done"},  32'(done_mask),        32'(e[W-4 -: N]));
      chk({tag, "_fmask"}, 32'(fail_mask),        32'(e[W-4-N -: N]));
      chk({tag, "_ffv"},   32'(first_fail_valid), 32'(e[IW+CW]));
      chk({tag, "_ffi"},   32'(first_fail_idx),   32'(e[CW +: IW]));
      chk({tag, "_cnt"},   32'(cycle_count),      32'(e[CW-1:0]));
      chk({tag, "_run"},   32'(running),          32'(0));
      chk({tag, "_alld"},  32'(all_done),         32'(e[W-1] | e[W-2]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic report(input logic [N-1:0] d, input logic [N-1:0] f);
    test_done = d;
    test_fail = f;
    tick();
    test_done = '0;
    test_fail = '0;
  endtask

  task automatic wait_verdict(input string tag, input int budget);
    int n = 0;
    while (!(all_done || timed_out) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_wait"}, 32'(all_done | timed_out), 32'(1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_run"},  32'(running),          32'(0));
    chk({tag, "_alld"}, 32'(all_done),         32'(0));
    chk({tag, "_tmo"},  32'(timed_out),        32'(0));
    chk({tag, "_done"}, 32'(done_mask),        32'(0));
    chk({tag, "_fm"},   32'(fail_mask),        32'(0));
    chk({tag, "_ffv"},  32'(first_fail_valid), 32'(0));
    chk({tag, "_ffi"},  32'(first_fail_idx),   32'(0));
    chk({tag, "_cnt"},  32'(cycle_count),      32'(0));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    // Reset state.
    reset = 1'b1;
    #2;
    check_all_zero("reset");
    tick();
    reset = 1'b0;
    tick();
    check_all_zero("idle");
    // test_done in IDLE is ignored.
    report(8'hFF, 8'hFF);
    check_all_zero("idle_ign");

    // Run 1: bits 0..7 one per cycle, no failures.
    exp_q.push_back(mk_exp(1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 16'd8));
    do_start();
    chk("r1_running", 32'(running), 32'(1));
    chk("r1_cnt0", 32'(cycle_count), 32'(0));
    for (int i = 0; i < N; i++) begin
      if (i == N - 1) chk("r1_pre_last", 32'(all_done), 32'(0));
      report(8'(1 << i), 8'h00);
    end
    check_verdict("r1");
    // Terminal state freezes records.
    report(8'h00, 8'h00);
    chk("r1_frozen_cnt", 32'(cycle_count), 32'(8));

    // Run 2: bits 2 and 5 fail together, bit 6 fails later.
    exp_q.push_back(mk_exp(0, 1, 0, 8'hFF, 8'h64, 1, 3'd2, 16'd7));
    do_start();
    chk("r2_cleared", 32'(done_mask), 32'(0));
    report(8'h24, 8'h24);
    chk("r2_ffv", 32'(first_fail_valid), 32'(1));
    chk("r2_ffi", 32'(first_fail_idx), 32'(2));
    report(8'h01, 8'h00);
    report(8'h02, 8'h00);
    report(8'h08, 8'h00);
    report(8'h10, 8'h00);
    report(8'h40, 8'h40);
    chk("r2_ffi_kept", 32'(first_fail_idx), 32'(2));
    report(8'h80, 8'h00);
    check_verdict("r2");
    report(8'hFF, 8'hFF);
    chk("r2_frozen_fm", 32'(fail_mask), 32'(8'h64));

    // Run 3: bit 7 never completes -> timeout after TO cycles.
    exp_q.push_back(mk_exp(0, 0, 1, 8'h7F, 8'h00, 0, 3'd0, 16'(TO)));
    do_start();
    for (int i = 0; i < N - 1; i++) report(8'(1 << i), 8'h00);
    wait_verdict("r3", 40);
    check_verdict("r3");
    report(8'h80, 8'h00);
    chk("r3_frozen_done", 32'(done_mask), 32'(8'h7F));
    chk("r3_frozen_tmo", 32'(timed_out), 32'(1));

    // Run 4: final bit arrives exactly on the timeout edge -> PASS.
    exp_q.push_back(mk_exp(1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 16'(TO)));
    do_start();
    for (int i = 0; i < N - 1; i++) report(8'(1 << i), 8'h00);
    for (int i = N - 1; i < TO - 1; i++) tick();
    chk("r4_still_run", 32'(running), 32'(1));
    chk("r4_cnt_last", 32'(cycle_count), 32'(TO - 1));
    report(8'h80, 8'h00);
    check_verdict("r4");

    // Run 5: bit 3 re-reports as failed (ignored); start in RUN ignored.
    exp_q.push_back(mk_exp(1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 16'd3));
    do_start();
    report(8'h08, 8'h00);
    start = 1'b1;
    report(8'h0F, 8'h08);
    start = 1'b0;
    chk("r5_no_restart", 32'(done_mask), 32'(8'h0F));
    chk("r5_fm", 32'(fail_mask), 32'(0));
    report(8'hF0, 8'h00);
    check_verdict("r5");

    // Run 6: asynchronous reset mid-run, then a clean run.
    do_start();
    for (int i = 0; i < 5; i++) report(8'(1 << i), 8'h00);
    chk("r6_cnt5", 32'(cycle_count), 32'(5));
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("r6_async");
    #1;
    reset = 1'b0;
    tick();
    check_all_zero("r6_after");
    exp_q.push_back(mk_exp(1, 0, 0, 8'hFF, 8'h00, 0, 3'd0, 16'd8));
    do_start();
    for (int i = 0; i < N; i++) report(8'(1 << ($urandom_range(0, 0) + i)), 8'h00);
    check_verdict("r6");

    chk("queue_drained", 32'(exp_q.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench cannot hang.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "time limit");
  end

endmodule
